// File: rtl/azadi_ctrl_pkg.sv
// azadi_ctrl_pkg: register offsets, CTRL bit indices and FSM state types for azadi_wb_soc_ctrl
package azadi_ctrl_pkg;
  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_CPB     = 8'h04;
  localparam logic [7:0] OFF_STATUS  = 8'h08;
  localparam logic [7:0] OFF_RST_CMD = 8'h0C;
  localparam logic [7:0] OFF_IRQ_STS = 8'h10;
  localparam int CTRL_SOC_RUN    = 0;
  localparam int CTRL_PROG_FORCE = 1;
  localparam int CTRL_PROG_SRC   = 2;
  localparam int CTRL_IRQ_EN     = 3;
  typedef enum logic [1:0] {SEQ_HALT, SEQ_RUN, SEQ_PULSE} seq_state_e;
  typedef enum logic {BUS_IDLE, BUS_ACK} bus_state_e;
endpackage

// File: rtl/azadi_rst_seq.sv
// azadi_rst_seq: SoC reset sequencer (in: run/halt/pulse strobes, cpb; out: soc_rst_no, clks_per_bit_o latched while in reset, state)
module azadi_rst_seq
  import azadi_ctrl_pkg::*;
#(
  parameter logic [15:0] CPB_RESET       = 16'd868,
  parameter int          RST_HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_stb,
  input  logic        halt_stb,
  input  logic        pulse_stb,
  input  logic [15:0] cpb,
  output logic        soc_rst_no,
  output logic [15:0] clks_per_bit_o,
  output seq_state_e  state
);
  seq_state_e state_d;
  logic [15:0] cnt, cnt_d;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    if (halt_stb) begin
      state_d = SEQ_HALT;
      cnt_d = '0;
    end else if (state == SEQ_HALT && run_stb) begin
      state_d = SEQ_RUN;
    end else if (state == SEQ_RUN && pulse_stb) begin
      state_d = SEQ_PULSE;
      cnt_d = 16'(RST_HOLD_CYCLES - 1);
    end else if (state == SEQ_PULSE) begin
      state_d = cnt == '0 ? SEQ_RUN : SEQ_PULSE;
      cnt_d = cnt == '0 ? cnt : cnt - 16'd1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEQ_HALT;
      cnt <= '0;
      soc_rst_no <= 1'b0;
      clks_per_bit_o <= CPB_RESET;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      soc_rst_no <= state_d == SEQ_RUN;
      clks_per_bit_o <= soc_rst_no ? clks_per_bit_o : cpb;
    end
  end
endmodule

// File: rtl/azadi_wb_soc_ctrl.sv
// azadi_wb_soc_ctrl: Wishbone slave (wbs_*) for SoC reset sequencing (soc_rst_no), UART divisor (clks_per_bit_o), PROG select (prog_pad_i->prog_o) and boot-LED IRQ (boot_led_i->irq_o)
module azadi_wb_soc_ctrl
  import azadi_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
  parameter logic [15:0] CPB_RESET       = 16'd868,
  parameter int          RST_HOLD_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        soc_rst_no,
  output logic [15:0] clks_per_bit_o,
  output logic        prog_o,
  input  logic        prog_pad_i,
  input  logic        boot_led_i,
  output logic        irq_o
);
  bus_state_e bus_state, bus_d;
  seq_state_e seq_state;
  logic [3:0] ctrl;
  logic [15:0] cpb;
  logic [31:0] rdata;
  logic [7:0] off;
  logic hit, req, wr, wr_ctrl, wr_cpb, wr_rst, clr_irq;
  logic run_stb, halt_stb, pulse_stb;
  logic prog_s1, prog_s2, led_q, led_qq, irq_sts;
  logic unused_ok;
  assign unused_ok = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};
  assign off = wbs_adr_i[7:0];
  assign hit = wbs_adr_i[31:8] == BASE_ADDR[31:8];
  assign req = bus_state == BUS_IDLE && wbs_stb_i && wbs_cyc_i && hit;
  assign wr = req && wbs_we_i;
  assign wr_ctrl = wr && off == OFF_CTRL && wbs_sel_i[0];
  assign wr_cpb = wr && off == OFF_CPB;
  assign wr_rst = wr && off == OFF_RST_CMD && wbs_sel_i[0] && wbs_dat_i[0];
  assign clr_irq = wr && off == OFF_IRQ_STS && wbs_sel_i[0] && wbs_dat_i[0];
  assign wbs_ack_o = bus_state == BUS_ACK;
  assign prog_o = ctrl[CTRL_PROG_SRC] ? ctrl[CTRL_PROG_FORCE] : prog_s2;
  always_comb begin
    bus_d = req ? BUS_ACK : BUS_IDLE;
    rdata = off == OFF_CTRL    ? {28'b0, ctrl} :
            off == OFF_CPB     ? {16'b0, cpb} :
            off == OFF_STATUS  ? {28'b0, 2'(seq_state), boot_led_i, ~soc_rst_no} :
            off == OFF_IRQ_STS ? {31'b0, irq_sts} : '0;
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bus_state <= BUS_IDLE;
      wbs_dat_o <= '0;
      ctrl <= '0;
      cpb <= CPB_RESET;
      run_stb <= 1'b0;
      halt_stb <= 1'b0;
      pulse_stb <= 1'b0;
      prog_s1 <= 1'b0;
      prog_s2 <= 1'b0;
      led_q <= 1'b0;
      led_qq <= 1'b0;
      irq_sts <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      bus_state <= bus_d;
      wbs_dat_o <= req && !wbs_we_i ? rdata : '0;
      ctrl <= wr_ctrl ? wbs_dat_i[3:0] : ctrl;
      cpb[7:0] <= wr_cpb && wbs_sel_i[0] ? wbs_dat_i[7:0] : cpb[7:0];
      cpb[15:8] <= wr_cpb && wbs_sel_i[1] ? wbs_dat_i[15:8] : cpb[15:8];
      run_stb <= wr_ctrl && wbs_dat_i[CTRL_SOC_RUN];
      halt_stb <= wr_ctrl && !wbs_dat_i[CTRL_SOC_RUN];
      pulse_stb <= wr_rst;
      prog_s1 <= prog_pad_i;
      prog_s2 <= prog_s1;
      led_q <= boot_led_i;
      led_qq <= led_q;
      irq_sts <= (led_q && !led_qq) || (irq_sts && !clr_irq);
      irq_o <= irq_sts && ctrl[CTRL_IRQ_EN];
    end
  end
  azadi_rst_seq #(
    .CPB_RESET(CPB_RESET),
    .RST_HOLD_CYCLES(RST_HOLD_CYCLES)
  ) u_rst_seq (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .run_stb(run_stb),
    .halt_stb(halt_stb),
    .pulse_stb(pulse_stb),
    .cpb(cpb),
    .soc_rst_no(soc_rst_no),
    .clks_per_bit_o(clks_per_bit_o),
    .state(seq_state)
  );
endmodule
